// File: rtl/l15_anycore_resp_queue.sv
// l15_anycore_resp_queue: in-order DEPTH-entry buffer between the L1.5 response port and the AnyCore response encoder.
// Latency: push in cycle N is at the head in cycle N+1; 0 cycles through an empty queue when L15_RESP_QUEUE_BYPASS_EN is defined.
// Backpressure: resp_l15_ack drops only while full (never a function of enc_resp_ack); L1.5 holds val/word until acked.
module l15_anycore_resp_queue #(
    parameter int DEPTH      = 4,
    parameter int THREADID_W = 1,
    parameter int PADDR_W    = 40,
    // Derived from the packed field list; not meant to be overridden.
    parameter int RESP_W     = 289 + THREADID_W + PADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     l15_resp_val,
    input  logic [RESP_W-1:0]        l15_resp_word,
    output logic                     resp_l15_ack,
    output logic                     enc_resp_val,
    output logic [RESP_W-1:0]        enc_resp_word,
    input  logic                     enc_resp_ack,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   max_occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PONE = PW'(1);

    // Payload is opaque here: the word is stored and returned bit-for-bit.
    logic [RESP_W-1:0] mem_q [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] occ_q, occ_d;
    logic [PW-1:0] max_q, max_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign occupancy     = occ_q;
    assign max_occupancy = max_q;

    // Handshakes: accept whenever not full, present the head whenever not empty.
    always_comb begin
        resp_l15_ack  = rst_n & l15_resp_val & ~full;
        enc_resp_val  = ~empty;
        enc_resp_word = mem_q[rd_ptr_q[AW-1:0]];
        push          = resp_l15_ack;
        pop           = enc_resp_ack & ~empty;
`ifdef L15_RESP_QUEUE_BYPASS_EN
        // Cut-through: an empty queue forwards the incoming word directly;
        // if the encoder takes it now, it never needs to be stored.
        if (empty && l15_resp_val) begin
            enc_resp_val  = 1'b1;
            enc_resp_word = l15_resp_word;
            if (enc_resp_ack) begin
                push = 1'b0;
            end
        end
`endif
    end

    // Next-state for pointers, occupancy and the high-water mark.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PONE;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + PONE;
            2'b01:   occ_d = occ_q - PONE;
            default: occ_d = occ_q;
        endcase
        // occ_d never exceeds DEPTH, so the peak saturates there naturally.
        max_d = (occ_d > max_q) ? occ_d : max_q;
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            max_q    <= max_d;
        end
    end

    // Storage write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= l15_resp_word;
        end
    end

`ifndef SYNTHESIS
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    logic stall_q;

    // Remember an unaccepted valid so a withdrawn request can be flagged next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= l15_resp_val & ~resp_l15_ack;
        end
    end

    // Occupancy bound and L1.5 hold-valid protocol.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (occ_q <= DEPTH_P)
                else $error("resp queue occupancy %0d exceeds DEPTH %0d", occ_q, DEPTH);
            assert (!(stall_q && !l15_resp_val))
                else $error("l15_resp_val withdrawn before resp_l15_ack");
        end
    end
`endif

endmodule

// File: tb/tb_l15_anycore_resp_queue.sv
// tb_l15_anycore_resp_queue: directed table plus randomized model-checked traffic for the L1.5 response queue.
// Latency: inputs driven on negedge, outputs sampled 4ns later (1ns before the next posedge).
// Backpressure: stimulus holds val/word while the expected ack is low.
module tb_l15_anycore_resp_queue;

    localparam int DEPTH      = 4;
    localparam int THREADID_W = 1;
    localparam int PADDR_W    = 40;
    localparam int RESP_W     = 289 + THREADID_W + PADDR_W;
    localparam int OW         = $clog2(DEPTH) + 1;

    localparam logic [3:0] RT_LOAD   = 4'h0;
    localparam logic [3:0] RT_IFILL  = 4'h1;
    localparam logic [3:0] RT_EVICT  = 4'h3;
    localparam logic [3:0] RT_ST_ACK = 4'h4;
    localparam logic [3:0] RT_INT    = 4'h7;

    typedef logic [RESP_W-1:0] word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          l15_resp_val;
    word_t         l15_resp_word;
    logic          resp_l15_ack;
    logic          enc_resp_val;
    word_t         enc_resp_word;
    logic          enc_resp_ack;
    logic [OW-1:0] occupancy;
    logic [OW-1:0] max_occupancy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    l15_anycore_resp_queue #(
        .DEPTH      (DEPTH),
        .THREADID_W (THREADID_W),
        .PADDR_W    (PADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .l15_resp_val  (l15_resp_val),
        .l15_resp_word (l15_resp_word),
        .resp_l15_ack  (resp_l15_ack),
        .enc_resp_val  (enc_resp_val),
        .enc_resp_word (enc_resp_word),
        .enc_resp_ack  (enc_resp_ack),
        .occupancy     (occupancy),
        .max_occupancy (max_occupancy)
    );

    task automatic chk_w(input string name, input word_t act, input word_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_s(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Recognisable word: returntype in the top nibble, tag in two places.
    function automatic word_t mk(input logic [3:0] rt, input logic [7:0] tag);
        word_t w;
        w = '0;
        w[RESP_W-1 -: 4] = rt;
        w[7:0]           = tag;
        w[100 +: 8]      = ~tag;
        return w;
    endfunction

    function automatic word_t rnd_word();
        logic [351:0] t;
        for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
        return t[RESP_W-1:0];
    endfunction

    // ---------------- reference model: a plain queue of words ----------------
    word_t mq[$];
    int    mmax;
    logic  last_stall;

    task automatic mstep(input logic v, input word_t w, input logic ea);
        logic  xa;
        logic  xe;
        logic  byp;
        word_t xw;
        l15_resp_val  = v;
        l15_resp_word = w;
        enc_resp_ack  = ea;
        xa  = v && (mq.size() < DEPTH);
        xe  = (mq.size() > 0);
        xw  = xe ? mq[0] : '0;
        byp = 1'b0;
`ifdef L15_RESP_QUEUE_BYPASS_EN
        if (mq.size() == 0 && v) begin
            xe  = 1'b1;
            xw  = w;
            byp = ea;
        end
`endif
        #4;
        chk_s("m_ack", 32'(resp_l15_ack), 32'(xa));
        chk_s("m_eval", 32'(enc_resp_val), 32'(xe));
        if (xe) chk_w("m_word", enc_resp_word, xw);
        chk_s("m_occ", 32'(occupancy), 32'(mq.size()));
        chk_s("m_max", 32'(max_occupancy), 32'(mmax));
        @(posedge clk);
        if (ea && mq.size() > 0) void'(mq.pop_front());
        if (xa && !byp) mq.push_back(w);
        if (mq.size() > mmax) mmax = mq.size();
        @(negedge clk);
        last_stall = v && !xa;
    endtask

    task automatic do_reset(input logic hold_val);
        rst_n         = 1'b0;
        l15_resp_val  = hold_val;
        l15_resp_word = mk(RT_LOAD, 8'hEE);
        enc_resp_ack  = 1'b0;
        #4;
        chk_s("rst_cycle_ack", 32'(resp_l15_ack), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        l15_resp_val = 1'b0;
        #1;
        chk_s("rst_occ", 32'(occupancy), 32'd0);
        chk_s("rst_max", 32'(max_occupancy), 32'd0);
        chk_s("rst_eval", 32'(enc_resp_val), 32'd0);
        chk_s("rst_ack", 32'(resp_l15_ack), 32'd0);
        @(negedge clk);
        mq.delete();
        mmax       = 0;
        last_stall = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          val;
        word_t         word;
        logic          eack;
        logic          x_ack;
        logic          x_eval;
        logic          chk_word;
        word_t         x_word;
        logic [OW-1:0] x_occ;
        logic [OW-1:0] x_max;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic v, input word_t w, input logic ea, input logic xa,
                                 input logic xe, input logic cw, input word_t xw,
                                 input int xo, input int xm);
        vec_t r;
        r.val = v; r.word = w; r.eack = ea; r.x_ack = xa; r.x_eval = xe;
        r.chk_word = cw; r.x_word = xw; r.x_occ = OW'(xo); r.x_max = OW'(xm);
        return r;
    endfunction

    task automatic apply(input vec_t r, input int idx);
        logic  xe;
        logic  cw;
        word_t xw;
        l15_resp_val  = r.val;
        l15_resp_word = r.word;
        enc_resp_ack  = r.eack;
        xe = r.x_eval;
        cw = r.chk_word;
        xw = r.x_word;
`ifdef L15_RESP_QUEUE_BYPASS_EN
        if (r.x_occ == '0 && r.val) begin
            xe = 1'b1;
            cw = 1'b1;
            xw = r.word;
        end
`endif
        #4;
        chk_s($sformatf("tbl%0d_ack", idx), 32'(resp_l15_ack), 32'(r.x_ack));
        chk_s($sformatf("tbl%0d_eval", idx), 32'(enc_resp_val), 32'(xe));
        if (cw) chk_w($sformatf("tbl%0d_word", idx), enc_resp_word, xw);
        chk_s($sformatf("tbl%0d_occ", idx), 32'(occupancy), 32'(r.x_occ));
        chk_s($sformatf("tbl%0d_max", idx), 32'(max_occupancy), 32'(r.x_max));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        word_t wa5, w1, w2, w3, w4, w5, w6, z;
        logic [3:0] rts [5];
        rts[0] = RT_INT; rts[1] = RT_IFILL; rts[2] = RT_LOAD; rts[3] = RT_ST_ACK; rts[4] = RT_EVICT;
        z   = '0;
        wa5 = mk(RT_IFILL, 8'hA5);
        w1  = mk(RT_INT, 8'h11);
        w2  = mk(RT_IFILL, 8'h22);
        w3  = mk(RT_LOAD, 8'h33);
        w4  = mk(RT_ST_ACK, 8'h44);
        w5  = mk(RT_EVICT, 8'h55);
        w6  = mk(RT_LOAD, 8'h66);

        // single push with ack tied to val, then fill past full, full steady state, drain
        tbl.push_back(row(1, wa5, 0, 1, 0, 0, z,   0, 0));
        tbl.push_back(row(0, z,   1, 0, 1, 1, wa5, 1, 1));
        tbl.push_back(row(0, z,   0, 0, 0, 0, z,   0, 1));
        tbl.push_back(row(1, w1,  0, 1, 0, 0, z,   0, 1));
        tbl.push_back(row(1, w2,  0, 1, 1, 1, w1,  1, 1));
        tbl.push_back(row(1, w3,  0, 1, 1, 1, w1,  2, 2));
        tbl.push_back(row(1, w4,  0, 1, 1, 1, w1,  3, 3));
        tbl.push_back(row(1, w5,  0, 0, 1, 1, w1,  4, 4));
        tbl.push_back(row(1, w5,  1, 0, 1, 1, w1,  4, 4));
        tbl.push_back(row(1, w5,  1, 1, 1, 1, w2,  3, 4));
        tbl.push_back(row(1, w6,  1, 1, 1, 1, w3,  3, 4));
        tbl.push_back(row(0, z,   1, 0, 1, 1, w4,  3, 4));
        tbl.push_back(row(0, z,   1, 0, 1, 1, w5,  2, 4));
        tbl.push_back(row(0, z,   1, 0, 1, 1, w6,  1, 4));
        tbl.push_back(row(0, z,   0, 0, 0, 0, z,   0, 4));

        rst_n = 1'b0; l15_resp_val = 1'b0; enc_resp_ack = 1'b0; l15_resp_word = '0;
        do_reset(1'b1);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // reset with three entries queued discards them
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) mstep(1'b1, mk(rts[i], 8'(8'hC0 + i)), 1'b0);
        chk_s("pre_rst_occ", 32'(occupancy), 32'd3);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) apply(tbl[i], 100 + i);

        // wrap-around: 10 push/pop pairs
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) mstep(1'b1, mk(rts[i % 5], 8'(8'h80 + i)), 1'b1);
        for (int i = 0; i < 2; i++) mstep(1'b0, z, 1'b1);

        // empty queue, push with simultaneous ack (cut-through when bypass is built in)
        do_reset(1'b0);
        mstep(1'b1, mk(RT_INT, 8'h3C), 1'b1);
        mstep(1'b0, z, 1'b0);
        mstep(1'b0, z, 1'b1);

        // randomized traffic: a filling phase then a draining phase
        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            logic  v;
            logic  ea;
            word_t w;
            if (last_stall) begin
                v = 1'b1;
                w = l15_resp_word;
            end else begin
                v = ($urandom_range(0, 99) < 65);
                w = rnd_word();
            end
            ea = ($urandom_range(0, 99) < ((i < 200) ? 35 : 75));
            mstep(v, w, ea);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/l15_anycore_resp_queue.md
Name: l15_anycore_resp_queue

Overview:
- Response buffer between the L1.5 response interface and the L1.5-to-AnyCore response encoder.
- Accepts one L1.5 response per cycle and stores it as a packed word in a DEPTH-entry FIFO.
- Presents entries in order to the encoder with a val/ack handshake.
- Decouples the L1.5 acknowledge from encoder timing. Reports occupancy and the peak-occupancy high-water mark.

Parameters:
- DEPTH, 4: number of FIFO entries; power of two, minimum 2.
- THREADID_W, 1: thread-id field width.
- PADDR_W, 40: physical address width.
- RESP_W, 289+THREADID_W+PADDR_W: packed response width (derived; must not be overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- l15_resp_val  in  1  L1.5 response valid
- l15_resp_word  in  RESP_W  packed L1.5 response
- resp_l15_ack  out  1  response accepted this cycle
- enc_resp_val  out  1  head entry valid toward encoder
- enc_resp_word  out  RESP_W  head entry
- enc_resp_ack  in  1  encoder consumed head this cycle
- occupancy  out  $clog2(DEPTH)+1  current entry count
- max_occupancy  out  $clog2(DEPTH)+1  peak count since reset

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk. On reset:
  - occupancy, max_occupancy, read pointer and write pointer all go to 0.
  - enc_resp_val=0, resp_l15_ack=0.
  - Storage array is not reset.
- Packing, MSB to LSB: returntype[3:0], l2miss, error[1:0], noncacheable, atomic, threadid, prefetch, f4b, data_3, data_2, data_1, data_0, inval_icache_all_way, inval_dcache_all_way, address, inval_address_15_4[11:0], cross_invalidate, cross_invalidate_way[1:0], inval_dcache_inval, inval_icache_inval, inval_way[1:0], blockinitstore.
- The queue passes payload through unchanged and never inspects or modifies it.
- Pointers are $clog2(DEPTH)+1 bits, with the extra MSB used as a wrap bit.
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - Pointers wrap from DEPTH-1 to 0 and toggle the wrap bit.
- Push:
  - resp_l15_ack = l15_resp_val & ~full, combinational. There is no path from enc_resp_ack to resp_l15_ack.
  - When full, L1.5 holds its response until a later cycle.
  - On push, the word is written at the write pointer and the write pointer increments.
- Pop:
  - enc_resp_val = ~empty; enc_resp_word = entry at the read pointer.
  - enc_resp_ack is sampled only when enc_resp_val=1. enc_resp_ack while empty is ignored.
  - On pop, the read pointer increments.
- Latency: a push at cycle N is visible at enc_resp_val in cycle N+1 (empty queue, default build).
- Push and pop in the same cycle:
  - Both take effect; occupancy is unchanged.
  - When full, push is blocked even if a pop occurs.
  - When empty, only the push happens; the new entry is not visible until the next cycle.
- occupancy is registered: +1 on push only, -1 on pop only, unchanged on both or neither.
- max_occupancy is registered: updates to the next occupancy value when that value exceeds the current max. It saturates at DEPTH.
- Ordering is strict FIFO: no reordering and no dropping for any returntype (INT, IFILL, LOAD, ST_ACK, EVICT).
- Reset asserted mid-operation discards all entries. No ack is issued in the reset cycle.
- Simulation assertions (excluded from synthesis): error on occupancy>DEPTH; error on l15_resp_val dropped while resp_l15_ack=0 (L1.5 must hold val).

Optional Feature:
- Macro: L15_RESP_QUEUE_BYPASS_EN.
- Enabled, cut-through when empty:
  - If empty & l15_resp_val, then enc_resp_val=1 and enc_resp_word=l15_resp_word in the same cycle.
  - If enc_resp_ack is also 1, the word is not written and pointers and occupancy are unchanged; resp_l15_ack=1.
  - If enc_resp_ack=0, the word is pushed normally.
- Disabled: minimum latency is 1 cycle, and enc_resp_* depends only on registered state.

Test Plan:
- Reset, then a single push of word 0x...A5 (returntype IFILL_RET) with enc_resp_ack tied to enc_resp_val -> resp_l15_ack=1 in cycle 0; enc_resp_val=1 with word 0x...A5 in cycle 1; occupancy returns to 0 in cycle 2; max_occupancy=1.
- DEPTH=4, enc_resp_ack=0, push 5 distinct words back-to-back -> resp_l15_ack=1 for the first 4 and 0 for the 5th; occupancy=4; max_occupancy=4. Then ack 4 times -> words emerge in push order, enc_resp_val=0 after the 4th.
- Steady-state full with simultaneous push and pop each cycle -> no push accepted while full; after one pop occupancy=3, then push and pop together hold it at 3 with data order preserved.
- Wrap-around: 10 push/pop pairs through DEPTH=4 -> all 10 words exit in order; wrap bits toggle; full is never falsely asserted.
- Reset asserted with occupancy=3 -> next cycle occupancy=0, enc_resp_val=0, max_occupancy=0; a subsequent push behaves as the first scenario.
- With L15_RESP_QUEUE_BYPASS_EN, empty queue, l15_resp_val=1 and enc_resp_ack=1 -> same-cycle enc_resp_word equals input; occupancy stays 0; max_occupancy stays 0.
